// File: rtl/vc_queue.sv
// vc_queue: NUM_VC independent FIFOs behind a single push port and a single pop port.
// Each port is steered by a VC index. Per-VC status (non-empty, almost-full, occupancy)
// is derived only from the registered counts.
// Optional feature: define VC_QUEUE_FLUSH_EN to add the flush_vc_i per-VC clear input.
module vc_queue #(
    parameter int unsigned NUM_VC          = 4,
    parameter int unsigned NUM_ENTRIES     = 8,
    parameter int unsigned DATA_WIDTH      = 128,
    parameter int unsigned AFULL_THRESHOLD = NUM_ENTRIES - 2,
    localparam int unsigned VCW            = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int unsigned PW             = $clog2(NUM_ENTRIES),
    localparam int unsigned CW             = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    push_data_i,
    input  logic [VCW-1:0]           push_vc_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [VCW-1:0]           pop_vc_i,
    input  logic                     pop_ready_i,
`ifdef VC_QUEUE_FLUSH_EN
    input  logic [NUM_VC-1:0]        flush_vc_i,
`endif
    output logic                     pop_valid_o,
    output logic [DATA_WIDTH-1:0]    pop_data_o,
    output logic [NUM_VC-1:0]        vc_valid_o,
    output logic [NUM_VC-1:0]        vc_afull_o,
    output logic [NUM_VC*CW-1:0]     vc_count_o
);

    localparam logic [CW-1:0] FullCount = CW'(NUM_ENTRIES);

    logic [DATA_WIDTH-1:0] mem_q [NUM_VC][NUM_ENTRIES];

    logic [PW-1:0] head_q  [NUM_VC];
    logic [PW-1:0] head_d  [NUM_VC];
    logic [PW-1:0] tail_q  [NUM_VC];
    logic [PW-1:0] tail_d  [NUM_VC];
    logic [CW-1:0] count_q [NUM_VC];
    logic [CW-1:0] count_d [NUM_VC];

    logic              push_in_range;
    logic              pop_in_range;
    logic [VCW-1:0]    push_idx;
    logic [VCW-1:0]    pop_idx;
    logic              push_fire;
    logic [NUM_VC-1:0] push_fire_vc;
    logic [NUM_VC-1:0] pop_fire_vc;
    logic [NUM_VC-1:0] flush;

`ifdef VC_QUEUE_FLUSH_EN
    assign flush = flush_vc_i;
`else
    assign flush = '0;
`endif

    // Out-of-range indices are folded to VC0 so array reads stay in bounds; the
    // in-range flags gate every use of the folded index.
    assign push_in_range = 32'(push_vc_i) < NUM_VC;
    assign pop_in_range  = 32'(pop_vc_i) < NUM_VC;
    assign push_idx      = push_in_range ? push_vc_i : '0;
    assign pop_idx       = pop_in_range ? pop_vc_i : '0;

    // Handshake outputs: full/empty come from the count alone, no pass-through on full.
    always_comb begin
        push_ready_o = push_in_range && (count_q[push_idx] != FullCount);
        pop_valid_o  = pop_in_range && (count_q[pop_idx] != '0);
        pop_data_o   = pop_in_range ? mem_q[pop_idx][tail_q[pop_idx]] : '0;
        push_fire    = push_valid_i && push_ready_o;
    end

    // Decode the shared push/pop ports into per-VC fire strobes.
    always_comb begin
        push_fire_vc = '0;
        pop_fire_vc  = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            push_fire_vc[v] = push_fire && (push_idx == VCW'(v));
            pop_fire_vc[v]  = pop_ready_i && pop_valid_o && (pop_idx == VCW'(v));
        end
    end

    // Per-VC pointer and occupancy next state; a flush overrides any push/pop that cycle.
    always_comb begin
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            head_d[v]  = head_q[v];
            tail_d[v]  = tail_q[v];
            count_d[v] = count_q[v];
            if (push_fire_vc[v]) begin
                head_d[v] = head_q[v] + PW'(1);
            end
            if (pop_fire_vc[v]) begin
                tail_d[v] = tail_q[v] + PW'(1);
            end
            unique case ({push_fire_vc[v], pop_fire_vc[v]})
                2'b10:   count_d[v] = count_q[v] + CW'(1);
                2'b01:   count_d[v] = count_q[v] - CW'(1);
                default: count_d[v] = count_q[v];
            endcase
            if (flush[v]) begin
                head_d[v]  = '0;
                tail_d[v]  = '0;
                count_d[v] = '0;
            end
        end
    end

    // Pointer and count registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                head_q[v]  <= '0;
                tail_q[v]  <= '0;
                count_q[v] <= '0;
            end
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                head_q[v]  <= head_d[v];
                tail_q[v]  <= tail_d[v];
                count_q[v] <= count_d[v];
            end
        end
    end

    // Flit storage is not reset; a flushed write is harmless since the head is cleared.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[push_idx][head_q[push_idx]] <= push_data_i;
        end
    end

    // Status outputs derived purely from registered counts.
    always_comb begin
        vc_valid_o = '0;
        vc_afull_o = '0;
        vc_count_o = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            vc_valid_o[v]            = count_q[v] != '0;
            vc_afull_o[v]            = 32'(count_q[v]) >= AFULL_THRESHOLD;
            vc_count_o[v*CW +: CW]   = count_q[v];
        end
    end

endmodule

// File: tb/tb_vc_queue.sv
// Bench for vc_queue: directed scenarios followed by random traffic, each cycle
// compared against per-VC queue model (default parameters: 4 VCs x 8 entries).
module tb_vc_queue;

    localparam int NV = 4;
    localparam int NE = 8;
    localparam int DW = 128;
    localparam int CW = 4;
    localparam int AF = NE - 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] push_data;
    logic [1:0]    push_vc;
    logic          push_valid;
    logic          push_ready;
    logic [1:0]    pop_vc;
    logic          pop_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic [NV-1:0] vc_valid;
    logic [NV-1:0] vc_afull;
    logic [NV*CW-1:0] vc_count;
    logic [NV-1:0] flush_vc;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [NV][$];

    always #5 clk = ~clk;

    vc_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_data_i  (push_data),
        .push_vc_i    (push_vc),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready),
        .pop_vc_i     (pop_vc),
        .pop_ready_i  (pop_ready),
`ifdef VC_QUEUE_FLUSH_EN
        .flush_vc_i   (flush_vc),
`endif
        .pop_valid_o  (pop_valid),
        .pop_data_o   (pop_data),
        .vc_valid_o   (vc_valid),
        .vc_afull_o   (vc_afull),
        .vc_count_o   (vc_count)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue model for the currently driven inputs.
    task automatic check_state(input string tag);
        for (int v = 0; v < NV; v++) begin
            check($sformatf("%s count%0d", tag, v), DW'(vc_count[v*CW +: CW]), DW'(mq[v].size()));
            check($sformatf("%s valid%0d", tag, v), DW'(vc_valid[v]), DW'(mq[v].size() != 0));
            check($sformatf("%s afull%0d", tag, v), DW'(vc_afull[v]), DW'(mq[v].size() >= AF));
        end
        check({tag, " push_ready"}, DW'(push_ready), DW'(mq[push_vc].size() != NE));
        check({tag, " pop_valid"}, DW'(pop_valid), DW'(mq[pop_vc].size() != 0));
        if (mq[pop_vc].size() != 0) begin
            check({tag, " pop_data"}, pop_data, mq[pop_vc][0]);
        end
    endtask

    // Drive inputs just after a falling edge, then let them settle.
    task automatic set(input logic pv, input logic [1:0] pvc, input logic [DW-1:0] pd,
                       input logic pr, input logic [1:0] ovc, input logic [NV-1:0] fl);
        push_valid = pv;
        push_vc    = pvc;
        push_data  = pd;
        pop_ready  = pr;
        pop_vc     = ovc;
        flush_vc   = fl;
        #1;
    endtask

    // Check, take one rising edge, advance the model, return at the falling edge.
    task automatic step(input string tag);
        bit            pf;
        bit            qf;
        logic [DW-1:0] d;
        logic [1:0]    pvc;
        logic [1:0]    ovc;
        logic [NV-1:0] fl;
        check_state(tag);
        pvc = push_vc;
        ovc = pop_vc;
        d   = push_data;
        pf  = push_valid && (mq[pvc].size() != NE);
        qf  = pop_ready && (mq[ovc].size() != 0);
`ifdef VC_QUEUE_FLUSH_EN
        fl  = flush_vc;
`else
        fl  = '0;
`endif
        @(posedge clk);
        if (qf) void'(mq[ovc].pop_front());
        if (pf) mq[pvc].push_back(d);
        for (int v = 0; v < NV; v++) begin
            if (fl[v]) mq[v].delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        push_valid = 1'b0;
        push_vc    = '0;
        push_data  = '0;
        pop_ready  = 1'b0;
        pop_vc     = '0;
        flush_vc   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle after reset: every in-range VC accepts.
        for (int v = 0; v < NV; v++) begin
            set(1'b0, 2'(v), '0, 1'b0, 2'(v), '0);
            check($sformatf("reset push_ready vc%0d", v), DW'(push_ready), DW'(1));
            check($sformatf("reset pop_valid vc%0d", v), DW'(pop_valid), DW'(0));
            step("reset");
        end
        check("reset vc_count", DW'(vc_count), DW'(0));

        // Three flits through VC2 in order.
        set(1'b1, 2'd2, DW'('hA1), 1'b0, 2'd2, '0); step("pushA1");
        check("A1 visible", pop_data, DW'('hA1));
        set(1'b1, 2'd2, DW'('hA2), 1'b0, 2'd2, '0); step("pushA2");
        set(1'b1, 2'd2, DW'('hA3), 1'b0, 2'd2, '0); step("pushA3");
        set(1'b0, 2'd0, '0, 1'b1, 2'd2, '0); check("pop A1", pop_data, DW'('hA1)); step("popA1");
        set(1'b0, 2'd0, '0, 1'b1, 2'd2, '0); check("pop A2", pop_data, DW'('hA2)); step("popA2");
        set(1'b0, 2'd0, '0, 1'b1, 2'd2, '0); check("pop A3", pop_data, DW'('hA3)); step("popA3");
        set(1'b0, 2'd0, '0, 1'b1, 2'd2, '0);
        check("VC2 drained pop_valid", DW'(pop_valid), DW'(0));
        check("VC2 drained count", DW'(vc_count[2*CW +: CW]), DW'(0));
        step("popEmpty");

        // Fill VC1 to full, watching the almost-full boundary.
        for (int i = 0; i < NE; i++) begin
            set(1'b1, 2'd1, DW'('hB0 + i), 1'b0, 2'd1, '0);
            step("fill");
            if (i == AF - 2) check("afull below threshold", DW'(vc_afull[1]), DW'(0));
            if (i == AF - 1) check("afull at threshold", DW'(vc_afull[1]), DW'(1));
        end
        set(1'b0, 2'd1, '0, 1'b0, 2'd1, '0);
        check("full VC1 push_ready", DW'(push_ready), DW'(0));
        set(1'b0, 2'd0, '0, 1'b0, 2'd1, '0);
        check("VC0 push_ready while VC1 full", DW'(push_ready), DW'(1));
        step("fullIdle");

        // Full VC1: only the pop fires, then both fire.
        set(1'b1, 2'd1, DW'('hC0), 1'b1, 2'd1, '0);
        check("full no pass-through", DW'(push_ready), DW'(0));
        step("fullPushPop");
        check("count 8->7", DW'(vc_count[1*CW +: CW]), DW'(7));
        set(1'b1, 2'd1, DW'('hC1), 1'b1, 2'd1, '0);
        check("ready after pop", DW'(push_ready), DW'(1));
        step("bothFire");
        check("count stays 7", DW'(vc_count[1*CW +: CW]), DW'(7));
        for (int i = 0; i < 12; i++) begin
            set(1'b1, 2'd1, DW'('hD0 + i), 1'b1, 2'd1, '0);
            step("wrap");
        end

        // Push VC0 and pop VC3 in the same cycle.
        set(1'b1, 2'd3, DW'('hE1), 1'b0, 2'd3, '0); step("pushE1");
        set(1'b1, 2'd3, DW'('hE2), 1'b0, 2'd3, '0); step("pushE2");
        set(1'b1, 2'd0, DW'('hF0), 1'b1, 2'd3, '0);
        check("VC3 oldest", pop_data, DW'('hE1));
        step("crossVc");
        check("VC0 0->1", DW'(vc_count[0*CW +: CW]), DW'(1));
        check("VC3 2->1", DW'(vc_count[3*CW +: CW]), DW'(1));

`ifdef VC_QUEUE_FLUSH_EN
        // Flush beats a simultaneous push to the same VC.
        for (int i = 0; i < 5; i++) begin
            set(1'b1, 2'd2, rnd_data(), 1'b0, 2'd0, '0);
            step("preFlush");
        end
        set(1'b1, 2'd2, DW'('h99), 1'b0, 2'd2, 4'b0100);
        check("flush-cycle push_ready", DW'(push_ready), DW'(1));
        step("flush");
        check("flushed count", DW'(vc_count[2*CW +: CW]), DW'(0));
        check("flushed valid", DW'(vc_valid[2]), DW'(0));
`endif

        // Random traffic across all VCs.
        for (int i = 0; i < 400; i++) begin
            logic [NV-1:0] fl;
            fl = '0;
`ifdef VC_QUEUE_FLUSH_EN
            if ($urandom_range(0, 19) == 0) fl = NV'($urandom);
`endif
            set(1'($urandom_range(0, 3) != 0), 2'($urandom), rnd_data(),
                1'($urandom_range(0, 2) == 0), 2'($urandom), fl);
            step("random");
        end

        // Reset in the middle of a burst clears everything at once.
        for (int i = 0; i < 6; i++) begin
            set(1'b1, 2'(i % NV), rnd_data(), 1'b0, 2'd0, '0);
            step("burst");
        end
        set(1'b1, 2'd1, rnd_data(), 1'b1, 2'd0, '0);
        rst_n = 1'b0;
        #1;
        check("async reset vc_count", DW'(vc_count), DW'(0));
        check("async reset pop_valid", DW'(pop_valid), DW'(0));
        check("async reset vc_valid", DW'(vc_valid), DW'(0));
        for (int v = 0; v < NV; v++) mq[v].delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int v = 0; v < NV; v++) begin
            set(1'b0, 2'(v), '0, 1'b1, 2'(v), '0);
            step("postReset");
        end
        set(1'b1, 2'd3, DW'('h55), 1'b0, 2'd3, '0); step("postResetPush");
        set(1'b0, 2'd0, '0, 1'b1, 2'd3, '0);
        check("postReset new flit", pop_data, DW'('h55));
        step("postResetPop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
